// File: rtl/pir_pkg.sv
// -----------------------------------------------------------------------------
// pir_pkg
// Shared definitions for the PIR input conditioner: FSM state type with fixed
// encodings, plus a helper that tells whether a state drives motion high.
// -----------------------------------------------------------------------------
package pir_pkg;

   typedef enum logic [1:0] {
      ST_WARMUP = 2'b00,
      ST_IDLE   = 2'b01,
      ST_ACTIVE = 2'b10,
      ST_HOLD   = 2'b11
   } pir_state_t;

   // motion is asserted while a detection is live or being stretched
   function automatic logic is_motion_state(input pir_state_t st);
      logic v;
      case (st)
         ST_ACTIVE: v = 1'b1;
         ST_HOLD:   v = 1'b1;
         default:   v = 1'b0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/pir_debounce.sv
// -----------------------------------------------------------------------------
// pir_debounce
// Two-flop synchroniser followed by a debounce filter. The filtered level only
// flips after the synchronised input has disagreed with it for DEBOUNCE_CYCLES
// consecutive cycles; any agreeing cycle restarts the count.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   din    in   raw asynchronous input
//   dout   out  debounced level (registered)
// -----------------------------------------------------------------------------
module pir_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_deb;
   logic [CW-1:0] r_cnt;

   // synchroniser chain and disagreement counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_deb   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= din;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_deb) begin
            if (r_cnt == CNT_LAST) begin
               r_deb <= r_sync2;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign dout = r_deb;

endmodule

// File: rtl/pir_conditioner.sv
// -----------------------------------------------------------------------------
// pir_conditioner
// Conditions the raw PIR sensor line for the PIR_LED block: synchronise,
// debounce, then stretch each detection with a retriggerable hold timer.
// Also emits a one-cycle start pulse per new event and a saturating count.
//
// Build option: define PIR_WARMUP_EN to add a post-reset lockout of
// WARMUP_CYCLES cycles (state WARMUP, counter, registered ready). Without it
// the design starts in IDLE and ready is tied high; ports are unchanged.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   pir_sensor   in   raw asynchronous sensor line
//   event_clr    in   synchronous clear of event_count (wins over increment)
//   motion       out  conditioned motion level (registered)
//   motion_start out  one-cycle pulse on a new event (registered)
//   event_count  out  saturating event count (registered)
//   ready        out  high once warm-up lockout is over
// -----------------------------------------------------------------------------
module pir_conditioner
   import pir_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned HOLD_CYCLES     = 1000,
   parameter int unsigned WARMUP_CYCLES   = 1000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pir_sensor,
   input  logic             event_clr,
   output logic             motion,
   output logic             motion_start,
   output logic [CNT_W-1:0] event_count,
   output logic             ready
);

   localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

`ifdef PIR_WARMUP_EN
   localparam int unsigned WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
   localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
   localparam pir_state_t RESET_STATE = ST_WARMUP;
`else
   localparam pir_state_t RESET_STATE = ST_IDLE;
`endif

   logic             w_deb;
   pir_state_t       r_state;
   pir_state_t       w_state_nxt;
   logic [HW-1:0]    r_hold_cnt;
   logic [HW-1:0]    w_hold_nxt;
   logic             w_new_event;
   logic [CNT_W-1:0] w_count_nxt;
   logic             r_motion;
   logic             r_motion_start;
   logic [CNT_W-1:0] r_event_count;
`ifdef PIR_WARMUP_EN
   logic [WW-1:0]    r_warm_cnt;
   logic [WW-1:0]    w_warm_nxt;
   logic             r_ready;
`endif

   pir_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (pir_sensor),
      .dout (w_deb)
   );

   // next-state, hold/warm-up counter and new-event decode
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold_cnt;
      w_new_event = 1'b0;
`ifdef PIR_WARMUP_EN
      w_warm_nxt  = r_warm_cnt;
`endif
      case (r_state)
         ST_WARMUP: begin
`ifdef PIR_WARMUP_EN
            // pir_deb is deliberately ignored until the lockout expires
            if (r_warm_cnt == WARM_LAST) begin
               w_state_nxt = ST_IDLE;
               w_warm_nxt  = '0;
            end else begin
               w_warm_nxt  = r_warm_cnt + WW'(1);
            end
`else
            w_state_nxt = ST_IDLE;
`endif
         end
         ST_IDLE: begin
            if (w_deb) begin
               w_state_nxt = ST_ACTIVE;
               w_new_event = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (!w_deb) begin
               w_state_nxt = ST_HOLD;
               w_hold_nxt  = '0;
            end else begin
               w_state_nxt = ST_ACTIVE;
            end
         end
         ST_HOLD: begin
            // retrigger is tested first so it beats a simultaneous expiry
            if (w_deb) begin
               w_state_nxt = ST_ACTIVE;
               w_hold_nxt  = '0;
            end else if (r_hold_cnt == HOLD_LAST) begin
               w_state_nxt = ST_IDLE;
               w_hold_nxt  = '0;
            end else begin
               w_hold_nxt  = r_hold_cnt + HW'(1);
            end
         end
         default: begin
            w_state_nxt = RESET_STATE;
            w_hold_nxt  = '0;
         end
      endcase
   end

   // saturating event counter; clear takes priority over increment
   always_comb begin
      w_count_nxt = r_event_count;
      if (event_clr) begin
         w_count_nxt = '0;
      end else if (w_new_event && (r_event_count != CNT_MAX)) begin
         w_count_nxt = r_event_count + CNT_W'(1);
      end else begin
         w_count_nxt = r_event_count;
      end
   end

   // state, counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= RESET_STATE;
         r_hold_cnt     <= '0;
         r_motion       <= 1'b0;
         r_motion_start <= 1'b0;
         r_event_count  <= '0;
`ifdef PIR_WARMUP_EN
         r_warm_cnt     <= '0;
         r_ready        <= 1'b0;
`endif
      end else begin
         r_state        <= w_state_nxt;
         r_hold_cnt     <= w_hold_nxt;
         r_motion       <= is_motion_state(w_state_nxt);
         r_motion_start <= w_new_event;
         r_event_count  <= w_count_nxt;
`ifdef PIR_WARMUP_EN
         r_warm_cnt     <= w_warm_nxt;
         r_ready        <= (w_state_nxt != ST_WARMUP);
`endif
      end
   end

   assign motion       = r_motion;
   assign motion_start = r_motion_start;
   assign event_count  = r_event_count;
`ifdef PIR_WARMUP_EN
   assign ready        = r_ready;
`else
   assign ready        = 1'b1;
`endif

endmodule

// File: tb/tb_pir_conditioner.sv
// -----------------------------------------------------------------------------
// tb_pir_conditioner
// Directed stimulus for pir_conditioner with a behavioural reference model.
// The model describes the outputs from input history: the debounced level
// flips once the synchronised input (input delayed two samples) has disagreed
// with it for DEBOUNCE_CYCLES samples in a row; motion is on while the
// debounced level is high or was high within the last HOLD_CYCLES samples of
// an ongoing high period.
// -----------------------------------------------------------------------------
module tb_pir_conditioner;

   localparam int D    = 4;
   localparam int H    = 10;
   localparam int W    = 20;
   localparam int CW   = 2;
   localparam int MAXN = 8192;

   logic          clk;
   logic          rst_n;
   logic          pir_sensor;
   logic          event_clr;
   logic          motion;
   logic          motion_start;
   logic [CW-1:0] event_count;
   logic          ready;

   int checks = 0;
   int errors = 0;

   pir_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .HOLD_CYCLES    (H),
      .WARMUP_CYCLES  (W),
      .CNT_W          (CW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pir_sensor  (pir_sensor),
      .event_clr   (event_clr),
      .motion      (motion),
      .motion_start(motion_start),
      .event_count (event_count),
      .ready       (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit sens [MAXN];
   bit dh   [MAXN];
   int n;
   bit m_motion;
   bit m_start;
   int m_cnt;
   bit m_ready;

   function automatic bit ready_after(input int edges);
`ifdef PIR_WARMUP_EN
      return (edges >= W);
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_reset();
      n        = 0;
      dh[0]    = 1'b0;
      sens[0]  = 1'b0;
      m_motion = 1'b0;
      m_start  = 1'b0;
      m_cnt    = 0;
      m_ready  = ready_after(0);
   endtask

   task automatic model_step();
      bit d_prev;
      bit win;
      bit all_diff;
      bit s;
      bit new_motion;
      bit start;
      n++;
      if (n >= MAXN) begin
         $display("FAIL model_range actual=%0d required=%0d", n, MAXN - 1);
         $fatal(1, "model history exhausted");
      end
      sens[n] = pir_sensor;
      d_prev  = dh[n-1];
      win = 1'b0;
      for (int k = 1; k <= H; k++) begin
         if ((n - 1 - k) >= 0 && dh[n-1-k]) win = 1'b1;
      end
      all_diff = 1'b1;
      for (int k = 0; k < D; k++) begin
         if ((n - k) < 1) begin
            all_diff = 1'b0;
         end else begin
            s = ((n - k) >= 3) ? sens[n-k-2] : 1'b0;
            if (s == dh[n-1]) all_diff = 1'b0;
         end
      end
      dh[n] = all_diff ? ~dh[n-1] : dh[n-1];
      start      = m_ready && !m_motion && d_prev;
      new_motion = m_ready && (d_prev || (m_motion && win));
      if (event_clr) m_cnt = 0;
      else if (start && m_cnt < 3) m_cnt = m_cnt + 1;
      m_start  = start;
      m_motion = new_motion;
      m_ready  = ready_after(n);
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // per-cycle compare against the model
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("model_motion", int'(motion), int'(m_motion));
            check("model_start",  int'(motion_start), int'(m_start));
            check("model_count",  int'(event_count), m_cnt);
            check("model_ready",  int'(ready), int'(m_ready));
         end
      end
   end

   // global watchdog
   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic do_reset(input logic sens_level);
      rst_n      = 1'b0;
      pir_sensor = sens_level;
      event_clr  = 1'b0;
      step(3);
      rst_n = 1'b1;
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!ready && t < 40) begin
         step(1);
         t++;
      end
      check("wait_ready", int'(ready), 1);
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while (motion && t < 80) begin
         step(1);
         t++;
      end
      check(name, int'(motion), 0);
      step(2);
   endtask

   initial begin
      pir_sensor = 1'b0;
      event_clr  = 1'b0;
      rst_n      = 1'b0;

`ifdef PIR_WARMUP_EN
      // warm-up with the sensor held high from reset
      do_reset(1'b1);
      check("warm_rst_count", int'(event_count), 0);
      for (int k = 0; k < W; k++) begin
         check("warm_ready_low", int'(ready), 0);
         check("warm_motion_low", int'(motion), 0);
         step(1);
      end
      check("warm_ready_high", int'(ready), 1);
      check("warm_motion_still_low", int'(motion), 0);
      step(1);
      check("warm_motion_rise", int'(motion), 1);
      check("warm_start", int'(motion_start), 1);
      check("warm_count", int'(event_count), 1);
      step(1);
      check("warm_start_width", int'(motion_start), 0);
      pir_sensor = 1'b0;
      wait_idle("warm_idle");
      do_reset(1'b0);
      wait_ready();
`else
      do_reset(1'b0);
      check("rst_ready", int'(ready), 1);
`endif
      check("rst_motion", int'(motion), 0);
      check("rst_start", int'(motion_start), 0);
      check("rst_count", int'(event_count), 0);

      // glitch rejection: 3-cycle pulse
      pir_sensor = 1'b1;
      step(3);
      pir_sensor = 1'b0;
      for (int k = 0; k < 20; k++) begin
         check("glitch_motion", int'(motion), 0);
         step(1);
      end
      check("glitch_count", int'(event_count), 0);

      // single clean 8-cycle event
      pir_sensor = 1'b1;
      step(6);
      check("single_motion_e6", int'(motion), 0);
      step(1);
      check("single_motion_e7", int'(motion), 1);
      check("single_start_e7", int'(motion_start), 1);
      check("single_count_e7", int'(event_count), 1);
      step(1);
      check("single_start_e8", int'(motion_start), 0);
      pir_sensor = 1'b0;
      step(16);
      check("single_motion_e24", int'(motion), 1);
      step(1);
      check("single_motion_e25", int'(motion), 0);
      check("single_count_end", int'(event_count), 1);
      step(3);

      // retrigger: debounced level returns 5 cycles after HOLD entry
      pir_sensor = 1'b1;
      step(7);
      check("retrig_start", int'(motion_start), 1);
      check("retrig_count_a", int'(event_count), 2);
      step(1);
      pir_sensor = 1'b0;
      step(5);
      pir_sensor = 1'b1;
      for (int k = 0; k < 30; k++) begin
         step(1);
         check("retrig_motion_held", int'(motion), 1);
         check("retrig_no_start", int'(motion_start), 0);
      end
      check("retrig_count_b", int'(event_count), 2);
      pir_sensor = 1'b0;
      wait_idle("retrig_idle");

      // clear coincident with motion_start
      pir_sensor = 1'b1;
      step(6);
      event_clr = 1'b1;
      step(1);
      event_clr = 1'b0;
      check("clr_start", int'(motion_start), 1);
      check("clr_count", int'(event_count), 0);
      step(1);
      pir_sensor = 1'b0;
      wait_idle("clr_idle");

      // saturation over four events
      for (int e = 0; e < 4; e++) begin
         pir_sensor = 1'b1;
         step(8);
         pir_sensor = 1'b0;
         wait_idle("sat_idle");
         check("sat_count", int'(event_count), (e + 1 > 3) ? 3 : e + 1);
      end

      // asynchronous reset while in HOLD
      pir_sensor = 1'b1;
      step(8);
      pir_sensor = 1'b0;
      step(12);
      check("hold_motion_before_rst", int'(motion), 1);
      check("hold_count_before_rst", int'(event_count), 3);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_motion", int'(motion), 0);
      check("arst_start", int'(motion_start), 0);
      check("arst_count", int'(event_count), 0);
      step(2);
      rst_n = 1'b1;
      step(3);
      check("post_rst_motion", int'(motion), 0);
      check("post_rst_count", int'(event_count), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pir_conditioner.md
# pir_conditioner

Input conditioning stage between the raw PIR sensor pin and the PIR_LED indicator block. It synchronises the asynchronous sensor line, rejects glitches with a debounce filter and stretches each detection with a retriggerable hold timer. Its `motion` output drives the LED block's `pir_sensor` input. It also reports a one-cycle start pulse and a saturating event count.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive cycles the synchronised input must differ from the filtered level before the filtered level flips; must be ≥1.
- `HOLD_CYCLES`, 1000: cycles `motion` stays high after the filtered input falls; must be ≥1.
- `WARMUP_CYCLES`, 1000: post-reset lockout length. Used only when `PIR_WARMUP_EN` is defined.
- `CNT_W`, 16: width of `event_count`.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `pir_sensor`, in, 1: raw asynchronous sensor line.
- `event_clr`, in, 1: synchronous clear of `event_count`.
- `motion`, out, 1: conditioned motion level; feeds PIR_LED.
- `motion_start`, out, 1: one-cycle pulse when a new motion event begins.
- `event_count`, out, CNT_W: number of motion events, saturating.
- `ready`, out, 1: high once the warm-up lockout has finished.

## Operation
- **Sync:** two-flop synchroniser produces `pir_sync`.
- **Debounce:**
  - Counter increments while `pir_sync != pir_deb`; it resets to 0 on any cycle where they are equal.
  - When the counter is at `DEBOUNCE_CYCLES-1` and the two still differ, `pir_deb` takes `pir_sync` and the counter resets.
- **FSM states:** WARMUP, IDLE, ACTIVE, HOLD.
  - WARMUP → IDLE when the warm-up counter reaches `WARMUP_CYCLES-1`.
  - IDLE → ACTIVE when `pir_deb` = 1. This is a new event: `motion_start` = 1 for that cycle and `event_count` increments.
  - ACTIVE → HOLD when `pir_deb` = 0. The hold counter is cleared.
  - HOLD → ACTIVE when `pir_deb` = 1. This is a retrigger: no `motion_start`, no count, hold counter cleared.
  - HOLD → IDLE when the hold counter reaches `HOLD_CYCLES-1` and `pir_deb` = 0.
  - If the retrigger and the hold expiry occur in the same cycle, the retrigger wins.
- **Outputs:**
  - `motion` is registered: 1 in ACTIVE and HOLD, 0 in WARMUP and IDLE.
  - `motion_start` and `event_count` are registered and change in the same cycle `motion` rises.
- **Counter rules:**
  - `event_count` saturates at all-ones.
  - `event_clr` forces 0 and wins over a simultaneous increment.
- **Reset values:**
  - `motion` = 0, `motion_start` = 0, `event_count` = 0.
  - Synchroniser flops = 0, `pir_deb` = 0, all counters = 0.
  - `ready` = 0 when `PIR_WARMUP_EN` is defined, otherwise 1.
- **Reset mid-operation:** asserting `rst_n` in any state clears everything immediately (asynchronous). No event is counted.

## Timing
- Number rising edges from 1, starting at the first edge that samples the new input level.
- **Rise latency:**
  - `pir_sync` changes at edge 2.
  - `pir_deb` changes at edge `DEBOUNCE_CYCLES`+2.
  - `motion` and `motion_start` are visible after edge `DEBOUNCE_CYCLES`+3.
- **Fall latency:**
  - `pir_deb` falls at edge `DEBOUNCE_CYCLES`+2.
  - HOLD is entered at edge `DEBOUNCE_CYCLES`+3.
  - `motion` falls `HOLD_CYCLES` edges after HOLD entry.
- **Glitch rejection:** input pulses shorter than `DEBOUNCE_CYCLES` cycles never reach `pir_deb`.
- **`motion_start`:** exactly one cycle wide; there are never two pulses within one continuous `motion` high period.

## Configuration
- **`PIR_WARMUP_EN` defined:**
  - Reset enters WARMUP; `ready` = 0 and `motion` = 0 for `WARMUP_CYCLES` cycles.
  - The debouncer runs during warm-up, but the FSM ignores `pir_deb`.
  - `ready` rises on entry to IDLE.
  - If `pir_deb` = 1 at that point, ACTIVE is entered on the next edge and counts as a new event.
- **`PIR_WARMUP_EN` undefined:**
  - The WARMUP state and its counter are not built.
  - Reset enters IDLE and `ready` is constant 1.
  - The port list is identical in both builds.

## Structure
- Shared package `pir_pkg`: FSM state typedef `pir_state_t` (WARMUP, IDLE, ACTIVE, HOLD) and its encodings.
- Sub-module `pir_debounce`: two-flop synchroniser plus debounce counter. Parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst_n`, `din`, `dout`.
- The top-level holds the FSM, the hold counter, the warm-up counter and the event counter.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=10, `WARMUP_CYCLES`=20, `CNT_W`=2.
- **Warm-up:** macro on, `pir_sensor` held 1 from reset → `ready` and `motion` stay 0 for 20 cycles. Then `ready` = 1, `motion` rises, `motion_start` pulses once and `event_count` = 1.
- **Glitch rejection:** 3-cycle high glitch on `pir_sensor` → `motion` stays 0 and `event_count` stays 0.
- **Single event:** 8-cycle clean high pulse → `motion` and `motion_start` visible after edge 7, `motion_start` one cycle wide. `motion` falls 10 edges after HOLD entry, `event_count` = 1.
- **Retrigger:** input goes high again 5 cycles into HOLD → `motion` never drops, no second `motion_start`, `event_count` unchanged.
- **Clear and saturation:**
  - `event_clr` in the same cycle as `motion_start` → `event_count` = 0.
  - Four separate events afterwards → `event_count` saturates at 3.
- **Reset in HOLD:** assert `rst_n` = 0 mid-HOLD → `motion`, `motion_start` and `event_count` go to 0 without waiting for a clock edge.
